// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arb_pkg
// Description : Shared definitions for the DMEM two-master arbiter: FSM state
//               encoding, master identifiers and the MMIO select bit index.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

    // FSM state encoding (IDLE = no owner, OWNx = master x holds a lock)
    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t OWN0 = 2'd1;
    localparam state_t OWN1 = 2'd2;

    // Master identifiers, also used as the one-hot grant bit index
    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    // Address bit that selects the MMIO space; it is passed through untouched
    localparam int MMIO_BIT = 31;

endpackage : dmem_arb_pkg
`default_nettype wire

// File: rtl/dmem_arbiter_rr_pick2.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick2
// Description : Combinational 2-way round-robin pick with lock ownership and
//               a starvation override.
//   req0/req1 : requests from master 0 / master 1
//   rr_last   : id of the master granted most recently (tie-break history)
//   own_vld   : a master currently owns the port (locked)
//   own_id    : id of the owner when own_vld = 1
//   starve    : owner has used up its burst allowance
//   gnt[1:0]  : one-hot grant, bit 0 = master 0, bit 1 = master 1
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick2 (
    input  logic       req0,
    input  logic       req1,
    input  logic       rr_last,
    input  logic       own_vld,
    input  logic       own_id,
    input  logic       starve,
    output logic [1:0] gnt
);

    logic w_own_req;
    logic w_oth_req;

    assign w_own_req = own_id ? req1 : req0;
    assign w_oth_req = own_id ? req0 : req1;

    always_comb begin
        gnt = 2'b00;
        if (own_vld) begin
            // The waiting master wins when the owner is idle this cycle or
            // has exhausted its burst allowance.
            if (w_oth_req && (starve || !w_own_req)) begin
                gnt = own_id ? 2'b01 : 2'b10;
            end else if (w_own_req) begin
                gnt = own_id ? 2'b10 : 2'b01;
            end
        end else if (req0 && req1) begin
            // Tie: the master that was not served last goes first
            gnt = rr_last ? 2'b01 : 2'b10;
        end else begin
            gnt = {req1, req0};
        end
    end

endmodule : rr_pick2
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Shares the single DMEM port between master 0 (CPU load/store)
//               and master 1 (debug loader / DMA). One access is granted per
//               cycle; read data comes back one cycle later with a valid
//               strobe to the master that issued the read.
//   clk, rst              : clock, synchronous active-high reset
//   mX_req/we/addr/wdata  : master X request, write flag, address, data
//   mX_lock               : master X asks to keep ownership
//   mX_gnt                : master X accepted this cycle (combinational)
//   mX_rvalid / mX_rdata  : read return for master X
//   mem_we/ask_addr/wdata : DMEM access port (combinational from winner)
//   mem_fetch_addr        : DMEM read-mux address, registered read address
//   mem_rdata             : DMEM read data, one cycle after the ask
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m0_lock,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_lock,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_ask_addr,
    output logic [ADDR_W-1:0] mem_fetch_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [7:0] c_max_burst = MAX_BURST[7:0];

    state_t            r_state;
    logic              r_rr_last;
    logic [7:0]        r_burst_cnt;
    logic [ADDR_W-1:0] r_fetch_addr;
    logic [ADDR_W-1:0] r_ask_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_rd_pend;
    logic              r_rd_id;

    logic              w_own_vld;
    logic              w_own_id;
    logic              w_starve;
    logic [1:0]        w_pick;
    logic [1:0]        w_gnt;
    logic              w_any;
    logic              w_win;
    logic              w_win_we;
    logic              w_win_lock;
    logic [ADDR_W-1:0] w_win_addr;
    logic [DATA_W-1:0] w_win_wdata;
    logic              w_win_other_req;
    logic              w_hold;
    logic              w_cnt_up;
    state_t            w_state_nxt;

    assign w_own_vld = (r_state != IDLE);
    assign w_own_id  = (r_state == OWN1);
    assign w_starve  = (r_burst_cnt == c_max_burst);

    rr_pick2 u_pick (
        .req0    (m0_req),
        .req1    (m1_req),
        .rr_last (r_rr_last),
        .own_vld (w_own_vld),
        .own_id  (w_own_id),
        .starve  (w_starve),
        .gnt     (w_pick)
    );

    // No grant can be issued while reset is asserted
    assign w_gnt = rst ? 2'b00 : w_pick;
    assign w_any = |w_gnt;
    assign w_win = w_gnt[1];

    assign w_win_we        = w_win ? m1_we    : m0_we;
    assign w_win_lock      = w_win ? m1_lock  : m0_lock;
    assign w_win_addr      = w_win ? m1_addr  : m0_addr;
    assign w_win_wdata     = w_win ? m1_wdata : m0_wdata;
    assign w_win_other_req = w_win ? m0_req   : m1_req;

    // A grant counts toward the burst when it goes to the owner, or when it
    // is the grant that takes the lock; it only counts while the other
    // master is waiting.
    assign w_hold   = w_any && (w_own_vld ? (w_win == w_own_id) : w_win_lock);
    assign w_cnt_up = w_hold && w_win_other_req;

    always_comb begin
        w_state_nxt = r_state;
        if (w_any) begin
            if (!w_own_vld) begin
                w_state_nxt = w_win_lock ? (w_win ? OWN1 : OWN0) : IDLE;
            end else if (w_win == w_own_id) begin
                w_state_nxt = w_win_lock ? r_state : IDLE;
            end else begin
                // Other master got in (idle gap or starvation): lock is lost
                w_state_nxt = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_rr_last    <= M1;
            r_burst_cnt  <= 8'd0;
            r_fetch_addr <= '0;
            r_ask_addr   <= '0;
            r_wdata      <= '0;
            r_rd_pend    <= 1'b0;
            r_rd_id      <= M0;
        end else begin
            r_state     <= w_state_nxt;
            r_burst_cnt <= w_cnt_up ? (r_burst_cnt + 8'd1) : 8'd0;
            r_rd_pend   <= w_any && !w_win_we;
            if (w_any) begin
                r_rr_last  <= w_win;
                r_ask_addr <= w_win_addr;
                r_wdata    <= w_win_wdata;
            end
            if (w_any && !w_win_we) begin
                r_fetch_addr <= w_win_addr;
                r_rd_id      <= w_win;
            end
        end
    end

    assign m0_gnt = w_gnt[0];
    assign m1_gnt = w_gnt[1];

    // Ask address and write data hold their last granted value when idle
    assign mem_we         = w_any && w_win_we;
    assign mem_ask_addr   = w_any ? w_win_addr  : r_ask_addr;
    assign mem_wdata      = w_any ? w_win_wdata : r_wdata;
    assign mem_fetch_addr = r_fetch_addr;

    // Gating with rst drops a read that was pending when reset arrived
    assign m0_rvalid = !rst && r_rd_pend && (r_rd_id == M0);
    assign m1_rvalid = !rst && r_rd_pend && (r_rd_id == M1);
    assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
    assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

endmodule : dmem_arbiter
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Self-checking bench for dmem_arbiter: a table of per-cycle
//               input/expected-output vectors plus hand-written sequences for
//               the locked burst limit and reset during a pending read.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, mem_we;
    logic [31:0] m0_rdata, m1_rdata, mem_ask_addr, mem_fetch_addr, mem_wdata, mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(8)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_lock(m0_lock), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_we(mem_we), .mem_ask_addr(mem_ask_addr), .mem_fetch_addr(mem_fetch_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic        rst;
        logic        r0, w0, l0;
        logic [31:0] a0, d0;
        logic        r1, w1, l1;
        logic [31:0] a1, d1;
        logic [31:0] rd;
        logic [1:0]  g;      // {m1_gnt, m0_gnt}
        logic [1:0]  rv;     // {m1_rvalid, m0_rvalid}
        logic        we;
        logic [31:0] ask, wd, fetch, rdat;
        logic        cs;     // check FSM state
        logic [1:0]  st;
    } vec_t;

    function automatic vec_t mk(
        input logic rs,
        input logic r0, input logic w0, input logic l0, input logic [31:0] a0, input logic [31:0] d0,
        input logic r1, input logic w1, input logic l1, input logic [31:0] a1, input logic [31:0] d1,
        input logic [31:0] rd, input logic [1:0] g, input logic [1:0] rv, input logic we,
        input logic [31:0] ask, input logic [31:0] wd, input logic [31:0] fetch,
        input logic [31:0] rdat, input logic cs, input logic [1:0] st);
        vec_t v;
        v.rst = rs; v.r0 = r0; v.w0 = w0; v.l0 = l0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.l1 = l1; v.a1 = a1; v.d1 = d1; v.rd = rd;
        v.g = g; v.rv = rv; v.we = we; v.ask = ask; v.wd = wd; v.fetch = fetch;
        v.rdat = rdat; v.cs = cs; v.st = st;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rs,
                         input logic r0, input logic w0, input logic l0, input logic [31:0] a0, input logic [31:0] d0,
                         input logic r1, input logic w1, input logic l1, input logic [31:0] a1, input logic [31:0] d1,
                         input logic [31:0] rd);
        rst = rs;
        m0_req = r0; m0_we = w0; m0_lock = l0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = w1; m1_lock = l1; m1_addr = a1; m1_wdata = d1;
        mem_rdata = rd;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs [16];

    initial begin
        int m1_cnt;
        bit m0_won;

        // Reset, tie alternation, MMIO write/read, idle gap in lock
        vecs[0]  = mk(1, 1,0,0,32'h100,0, 1,0,0,32'h200,0, 32'h0,         2'b00,2'b00,0, 32'h0,0,32'h0,0, 0,IDLE);
        vecs[1]  = mk(1, 1,0,0,32'h100,0, 1,0,0,32'h200,0, 32'h0,         2'b00,2'b00,0, 32'h0,0,32'h0,0, 1,IDLE);
        vecs[2]  = mk(0, 1,0,0,32'h100,0, 1,0,0,32'h200,0, 32'h11110000,  2'b01,2'b00,0, 32'h100,0,32'h0,0, 1,IDLE);
        vecs[3]  = mk(0, 1,0,0,32'h100,0, 1,0,0,32'h200,0, 32'hA0A0A0A0,  2'b10,2'b01,0, 32'h200,0,32'h100,32'hA0A0A0A0, 0,IDLE);
        vecs[4]  = mk(0, 1,0,0,32'h100,0, 1,0,0,32'h200,0, 32'hB1B1B1B1,  2'b01,2'b10,0, 32'h100,0,32'h200,32'hB1B1B1B1, 0,IDLE);
        vecs[5]  = mk(0, 1,0,0,32'h100,0, 1,0,0,32'h200,0, 32'hC2C2C2C2,  2'b10,2'b01,0, 32'h200,0,32'h100,32'hC2C2C2C2, 0,IDLE);
        vecs[6]  = mk(0, 0,0,0,32'h0,0,   0,0,0,32'h0,0,   32'hD3D3D3D3,  2'b00,2'b10,0, 32'h200,0,32'h200,32'hD3D3D3D3, 0,IDLE);
        vecs[7]  = mk(0, 0,0,0,32'h0,0,   0,0,0,32'h0,0,   32'hE4E4E4E4,  2'b00,2'b00,0, 32'h200,0,32'h200,0, 1,IDLE);
        vecs[8]  = mk(0, 1,1,0,32'h80000004,32'h0000BEEF, 0,0,0,32'h0,0, 32'h0, 2'b01,2'b00,1, 32'h80000004,32'h0000BEEF,32'h200,0, 0,IDLE);
        vecs[9]  = mk(0, 1,0,0,32'h80000000,0, 0,0,0,32'h0,0, 32'h0,      2'b01,2'b00,0, 32'h80000000,0,32'h200,0, 0,IDLE);
        vecs[10] = mk(0, 0,0,0,32'h0,0,   0,0,0,32'h0,0,   32'h12345678,  2'b00,2'b01,0, 32'h80000000,0,32'h80000000,32'h12345678, 0,IDLE);
        vecs[11] = mk(0, 1,0,1,32'h300,0, 0,0,0,32'h0,0,   32'h0,         2'b01,2'b00,0, 32'h300,0,32'h80000000,0, 1,IDLE);
        vecs[12] = mk(0, 1,0,1,32'h304,0, 1,0,0,32'h400,0, 32'h55,        2'b01,2'b01,0, 32'h304,0,32'h300,32'h55, 1,OWN0);
        vecs[13] = mk(0, 0,0,1,32'h0,0,   1,0,0,32'h400,0, 32'h66,        2'b10,2'b01,0, 32'h400,0,32'h304,32'h66, 1,OWN0);
        vecs[14] = mk(0, 1,0,0,32'h308,0, 1,0,0,32'h404,0, 32'h77,        2'b01,2'b10,0, 32'h308,0,32'h400,32'h77, 1,IDLE);
        vecs[15] = mk(0, 0,0,0,32'h0,0,   0,0,0,32'h0,0,   32'h88,        2'b00,2'b01,0, 32'h308,0,32'h308,32'h88, 1,IDLE);

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].rst, vecs[i].r0, vecs[i].w0, vecs[i].l0, vecs[i].a0, vecs[i].d0,
                  vecs[i].r1, vecs[i].w1, vecs[i].l1, vecs[i].a1, vecs[i].d1, vecs[i].rd);
            @(negedge clk);
            chk($sformatf("v%0d m0_gnt", i),    {31'd0, m0_gnt},    {31'd0, vecs[i].g[0]});
            chk($sformatf("v%0d m1_gnt", i),    {31'd0, m1_gnt},    {31'd0, vecs[i].g[1]});
            chk($sformatf("v%0d m0_rvalid", i), {31'd0, m0_rvalid}, {31'd0, vecs[i].rv[0]});
            chk($sformatf("v%0d m1_rvalid", i), {31'd0, m1_rvalid}, {31'd0, vecs[i].rv[1]});
            chk($sformatf("v%0d mem_we", i),    {31'd0, mem_we},    {31'd0, vecs[i].we});
            chk($sformatf("v%0d ask_addr", i),  mem_ask_addr,       vecs[i].ask);
            chk($sformatf("v%0d wdata", i),     mem_wdata,          vecs[i].wd);
            chk($sformatf("v%0d fetch_addr", i), mem_fetch_addr,    vecs[i].fetch);
            chk($sformatf("v%0d m0_rdata", i),  m0_rdata, vecs[i].rv[0] ? vecs[i].rdat : 32'h0);
            chk($sformatf("v%0d m1_rdata", i),  m1_rdata, vecs[i].rv[1] ? vecs[i].rdat : 32'h0);
            if (vecs[i].cs)
                chk($sformatf("v%0d state", i), {30'd0, dut.r_state}, {30'd0, vecs[i].st});
            next_cycle();
        end

        // Locked burst by m1 while m0 waits: bounded to MAX_BURST grants
        m1_cnt = 0;
        m0_won = 1'b0;
        for (int c = 0; c < 20 && !m0_won; c++) begin
            drive(0, 1,0,0,32'h500,0, 1,1,1,32'(m1_cnt*4),32'(m1_cnt), 32'h0);
            @(negedge clk);
            chk("burst gnt onehot", {31'd0, m0_gnt & m1_gnt}, 32'd0);
            if (m1_gnt) begin
                chk("burst mem_we", {31'd0, mem_we}, 32'd1);
                chk("burst ask_addr", mem_ask_addr, 32'(m1_cnt*4));
                m1_cnt++;
            end
            if (m0_gnt) m0_won = 1'b1;
            next_cycle();
        end
        chk("burst m0 granted", {31'd0, m0_won}, 32'd1);
        chk("burst m1 grants", 32'(m1_cnt), 32'd8);
        drive(0, 0,0,0,0,0, 0,0,0,0,0, 32'hCAFE0001);
        @(negedge clk);
        chk("burst state idle", {30'd0, dut.r_state}, {30'd0, IDLE});
        chk("burst m0_rvalid", {31'd0, m0_rvalid}, 32'd1);
        chk("burst m0_rdata", m0_rdata, 32'hCAFE0001);
        chk("burst fetch_addr", mem_fetch_addr, 32'h500);
        next_cycle();

        // Reset arriving the cycle after a granted m1 read drops the rvalid
        drive(0, 0,0,0,0,0, 1,0,0,32'h600,0, 32'h0);
        @(negedge clk);
        chk("rstrd m1_gnt", {31'd0, m1_gnt}, 32'd1);
        next_cycle();
        drive(1, 0,0,0,0,0, 0,0,0,0,0, 32'hDEAD0000);
        @(negedge clk);
        chk("rstrd m1_rvalid in rst", {31'd0, m1_rvalid}, 32'd0);
        chk("rstrd m1_rdata in rst", m1_rdata, 32'd0);
        next_cycle();
        drive(0, 0,0,0,0,0, 0,0,0,0,0, 32'hDEAD0001);
        @(negedge clk);
        chk("rstrd m1_rvalid after", {31'd0, m1_rvalid}, 32'd0);
        chk("rstrd fetch_addr", mem_fetch_addr, 32'd0);
        next_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_dmem_arbiter
`default_nettype wire
